// File: rtl/axi_burst_reader.sv
// rtl/axi_burst_reader.sv - AXI4 INCR-burst read master with length checking and buffered responses
module axi_burst_reader #(
    parameter int DW       = 512,
    parameter int AW       = 64,
    parameter int ID_WIDTH = 16,
    parameter int MAX_OUT  = 4
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       req_valid,
    input  logic [AW-1:0]              req_addr,
    input  logic [7:0]                 req_len,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [DW-1:0]              rsp_data,
    output logic                       rsp_last,
    output logic                       rsp_err,
    input  logic                       rsp_ready,
    output logic [ID_WIDTH-1:0]        m_axi_arid,
    output logic [AW-1:0]              m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [ID_WIDTH-1:0]        m_axi_rid,
    input  logic [DW-1:0]              m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err_sticky,
    output logic                       proto_err,
    input  logic                       err_clear
);

    localparam int SZ = $clog2(DW / 8);
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

    typedef enum logic {S_IDLE, S_ADDR} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    ar_addr_q;
    logic [7:0]       ar_len_q;

    logic [7:0]       len_mem [2**PW];
    logic [PW-1:0]    len_wr_ptr, len_rd_ptr;
    logic [7:0]       beat_cnt;

    logic [DW-1:0]    buf_data [2];
    logic             buf_last [2];
    logic             buf_err  [2];
    logic             buf_wr, buf_rd;
    logic [1:0]       buf_cnt;
    logic             r_init;

    logic             ar_hs, r_hs, rsp_hs, out_empty, retire, len_bad;
    logic             unused_bits;

    assign unused_bits = ^{m_axi_rid, m_axi_rresp[0], req_addr[SZ-1:0]};

    assign ar_hs     = m_axi_arvalid && m_axi_arready;
    assign r_hs      = m_axi_rvalid && m_axi_rready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign out_empty = (outstanding == '0);
    assign retire    = r_hs && m_axi_rlast && !out_empty;
    // A beat with nothing outstanding, or RLAST disagreeing with the expected length, is a protocol error
    assign len_bad   = r_hs && (out_empty || (m_axi_rlast != (beat_cnt == len_mem[len_rd_ptr])));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Length FIFO occupancy always equals outstanding, so one limit covers both
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = (outstanding < MAX_OUT_C);
                if (req_valid && req_ready) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ar_addr_q <= '0;
            ar_len_q  <= '0;
        end else if (req_valid && req_ready) begin
            ar_addr_q <= {req_addr[AW-1:SZ], {SZ{1'b0}}};
            ar_len_q  <= req_len;
        end
    end

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arlen   = ar_len_q;
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;

    always_ff @(posedge clk) begin
        if (ar_hs) len_mem[len_wr_ptr] <= ar_len_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            len_wr_ptr  <= '0;
            len_rd_ptr  <= '0;
            outstanding <= '0;
            beat_cnt    <= '0;
        end else begin
            if (ar_hs)  len_wr_ptr <= len_wr_ptr + PW'(1);
            if (retire) len_rd_ptr <= len_rd_ptr + PW'(1);
            case ({ar_hs, retire})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (r_hs && !out_empty) beat_cnt <= m_axi_rlast ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_sticky <= 1'b0;
            proto_err  <= 1'b0;
        end else if (err_clear) begin
            err_sticky <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (r_hs && m_axi_rresp[1]) err_sticky <= 1'b1;
            if (len_bad)                proto_err  <= 1'b1;
        end
    end

    // Two-entry response buffer; R acceptance depends only on free space
    always_ff @(posedge clk) begin
        if (r_hs) begin
            buf_data[buf_wr] <= m_axi_rdata;
            buf_last[buf_wr] <= m_axi_rlast;
            buf_err[buf_wr]  <= m_axi_rresp[1];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            buf_wr  <= 1'b0;
            buf_rd  <= 1'b0;
            buf_cnt <= 2'd0;
            r_init  <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (r_hs)   buf_wr <= ~buf_wr;
            if (rsp_hs) buf_rd <= ~buf_rd;
            case ({r_hs, rsp_hs})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    assign m_axi_rready = r_init && (buf_cnt != 2'd2);
    assign rsp_valid    = (buf_cnt != 2'd0);
    assign rsp_data     = buf_data[buf_rd];
    assign rsp_last     = buf_last[buf_rd];
    assign rsp_err      = buf_err[buf_rd];

endmodule

// File: tb/tb_axi_burst_reader.sv
// tb/tb_axi_burst_reader.sv - scoreboard bench for axi_burst_reader with a behavioural AXI read slave
module tb_axi_burst_reader;

    logic         clk = 1'b0;
    logic         nreset;
    logic         req_valid;
    logic [63:0]  req_addr;
    logic [7:0]   req_len;
    logic         req_ready;
    logic         rsp_valid;
    logic [511:0] rsp_data;
    logic         rsp_last;
    logic         rsp_err;
    logic         rsp_ready;
    logic [15:0]  m_axi_arid;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [15:0]  m_axi_rid;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [2:0]   outstanding;
    logic         err_sticky;
    logic         proto_err;
    logic         err_clear;

    axi_burst_reader #(.DW(512), .AW(64), .ID_WIDTH(16), .MAX_OUT(4)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .outstanding(outstanding), .err_sticky(err_sticky), .proto_err(proto_err),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic         err;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       r_q[$];
    logic [63:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];

    int vectors = 0;
    int miscompares = 0;
    int r_budget = -1;
    int err_beat = -1;
    int early_last = -1;
    int rsp_mode = 0;
    logic saw_full = 1'b0;

    function automatic logic [511:0] pat(logic [31:0] v);
        return {16{v}};
    endfunction

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(logic [31:0] base, int nbeats, int err_idx);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = pat(base + 32'(i));
            b.last = (i == nbeats - 1);
            b.err  = (i == err_idx);
            exp_q.push_back(b);
        end
    endtask

    task automatic issue(logic [63:0] addr, logic [7:0] len, logic [63:0] exp_addr);
        logic ok;
        exp_ar_addr.push_back(exp_addr);
        exp_ar_len.push_back(len);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = addr; req_len = len;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_accepted", 512'(ok), 512'd1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && outstanding == 3'd0) begin ok = 1'b1; break; end
        end
        check("drain_complete", 512'(ok), 512'd1);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        @(negedge clk);
    endtask

    // Response monitor: every delivered beat is matched against the scoreboard
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (nreset && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_beat: got data %0h, none expected", rsp_data[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_last", 512'(rsp_last), 512'(e.last));
                    check("rsp_err", 512'(rsp_err), 512'(e.err));
                end
            end
        end
    end

    // AR slave: checks each address beat and queues the R beats it will return
    initial begin
        beat_t b;
        logic [63:0] a;
        logic [7:0]  l;
        int n;
        forever begin
            @(posedge clk);
            if (nreset && m_axi_arvalid && m_axi_arready) begin
                a = m_axi_araddr; l = m_axi_arlen;
                if (exp_ar_addr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_ar: got araddr %0h", a);
                end else begin
                    check("araddr", 512'(a), 512'(exp_ar_addr.pop_front()));
                    check("arlen", 512'(l), 512'(exp_ar_len.pop_front()));
                    check("arid_size_burst", 512'({m_axi_arid, m_axi_arsize, m_axi_arburst}),
                          512'({16'h0, 3'd6, 2'b01}));
                end
                n = (early_last >= 0) ? early_last : int'(l);
                for (int i = 0; i <= n; i++) begin
                    b.data = pat(a[31:0] + 32'(i));
                    b.last = (i == n);
                    b.err  = (i == err_beat);
                    r_q.push_back(b);
                end
                err_beat = -1;
                early_last = -1;
            end
        end
    end

    // R driver: presents queued beats whenever the budget allows
    initial begin
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00; m_axi_rid = '0;
        forever begin
            @(posedge clk);
            if (nreset && m_axi_rvalid && m_axi_rready) begin
                void'(r_q.pop_front());
                if (r_budget > 0) r_budget--;
            end
            #1;
            if (r_q.size() > 0 && r_budget != 0) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = r_q[0].data;
                m_axi_rlast  = r_q[0].last;
                m_axi_rresp  = r_q[0].err ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ~rsp_ready;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (nreset && m_axi_rvalid && !m_axi_rready) saw_full = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
        err_clear = 1'b0; m_axi_arready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("reset_rsp_valid", 512'(rsp_valid), 512'd0);
        check("reset_arvalid", 512'(m_axi_arvalid), 512'd0);
        check("reset_rready", 512'(m_axi_rready), 512'd0);
        check("reset_outstanding", 512'(outstanding), 512'd0);
        check("reset_flags", 512'({err_sticky, proto_err}), 512'd0);
        nreset = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 512'(req_ready), 512'd1);

        // single burst
        push_exp(32'h1000, 4, -1);
        issue(64'h1000, 8'd3, 64'h1000);
        wait_idle();
        check("t1_outstanding", 512'(outstanding), 512'd0);

        // unaligned address
        push_exp(32'h1000, 1, -1);
        issue(64'h1027, 8'd0, 64'h1000);
        wait_idle();

        // outstanding limit
        r_budget = 0;
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h2000 + 32'(i * 64), 1, -1);
            issue(64'h2000 + 64'(i * 64), 8'd0, 64'h2000 + 64'(i * 64));
        end
        repeat (3) @(negedge clk);
        check("limit_outstanding", 512'(outstanding), 512'd4);
        check("limit_req_ready", 512'(req_ready), 512'd0);
        r_budget = 1;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(posedge clk);
                if (m_axi_rvalid && m_axi_rready) begin seen = 1'b1; break; end
            end
            check("limit_r_beat_seen", 512'(seen), 512'd1);
        end
        @(negedge clk);
        check("limit_req_ready_back", 512'(req_ready), 512'd1);
        check("limit_outstanding_dec", 512'(outstanding), 512'd3);
        push_exp(32'h2100, 1, -1);
        issue(64'h2100, 8'd0, 64'h2100);
        r_budget = -1;
        wait_idle();

        // backpressure
        saw_full = 1'b0;
        rsp_mode = 1;
        push_exp(32'h3000, 8, -1);
        issue(64'h3000, 8'd7, 64'h3000);
        wait_idle();
        check("bp_rready_dropped", 512'(saw_full), 512'd1);
        rsp_mode = 0;

        // SLVERR on beat 2
        err_beat = 1;
        push_exp(32'h4000, 4, 1);
        issue(64'h4000, 8'd3, 64'h4000);
        wait_idle();
        check("err_sticky_set", 512'(err_sticky), 512'd1);
        check("err_no_proto", 512'(proto_err), 512'd0);
        pulse_clear();
        check("err_sticky_cleared", 512'(err_sticky), 512'd0);

        // early RLAST
        early_last = 1;
        push_exp(32'h5000, 2, -1);
        issue(64'h5000, 8'd3, 64'h5000);
        wait_idle();
        check("proto_err_set", 512'(proto_err), 512'd1);
        check("proto_outstanding", 512'(outstanding), 512'd0);
        pulse_clear();
        check("proto_err_cleared", 512'(proto_err), 512'd0);
        push_exp(32'h6000, 2, -1);
        issue(64'h6000, 8'd1, 64'h6000);
        wait_idle();
        check("proto_resync", 512'(proto_err), 512'd0);

        // reset mid-burst
        rsp_mode = 2;
        issue(64'h7000, 8'd7, 64'h7000);
        repeat (6) @(negedge clk);
        check("midburst_outstanding", 512'(outstanding), 512'd1);
        nreset = 1'b0;
        #1;
        check("rst_rsp_valid", 512'(rsp_valid), 512'd0);
        check("rst_arvalid", 512'(m_axi_arvalid), 512'd0);
        check("rst_outstanding", 512'(outstanding), 512'd0);
        check("rst_rready", 512'(m_axi_rready), 512'd0);
        r_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        nreset = 1'b1;
        rsp_mode = 0;
        push_exp(32'h8000, 2, -1);
        issue(64'h8000, 8'd1, 64'h8000);
        wait_idle();
        check("post_reset_outstanding", 512'(outstanding), 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
